// File: rtl/time_display_if.sv
// -----------------------------------------------------------------------------
// time_display_if
// Connects the time counter (master) to the display scan driver (slave).
//   m_hr..l_sec  : BCD time digits, driven by the master
//   lz_blank     : blank the m_hr digit when it is 0
//   colon_blink  : 1 = colon blinks, 0 = colon steady on
//   an           : one-hot digit enable (bit 0 = l_sec ... bit 5 = m_hr)
//   seg          : segments {g,f,e,d,c,b,a}, active high
//   dp           : decimal point (colon), active high
//   frame_done   : one-cycle pulse at the end of each six-slot frame
// -----------------------------------------------------------------------------
interface time_display_if;
    logic [3:0] m_hr;
    logic [3:0] l_hr;
    logic [3:0] m_min;
    logic [3:0] l_min;
    logic [3:0] m_sec;
    logic [3:0] l_sec;
    logic       lz_blank;
    logic       colon_blink;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (
        output m_hr, l_hr, m_min, l_min, m_sec, l_sec, lz_blank, colon_blink,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  m_hr, l_hr, m_min, l_min, m_sec, l_sec, lz_blank, colon_blink,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/time_display_scan.sv
// -----------------------------------------------------------------------------
// time_display_scan
// Multiplexed six-digit seven-segment driver. A snapshot of all six BCD digits
// is taken at the start of each frame, so a counter rollover during the scan
// can never show a mixed time. Each digit slot lasts SCAN_DIV cycles and starts
// with BLANK dark cycles to suppress ghosting. The colon (dp of l_hr and l_min)
// toggles every COLON_FRAMES frames, or stays on when blinking is disabled.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-high reset
//   disp  : time_display_if.slave (digits/controls in, an/seg/dp/frame_done out)
// -----------------------------------------------------------------------------
module time_display_scan #(
    parameter int SCAN_DIV     = 1000,  // cycles per digit slot, >= BLANK+1
    parameter int BLANK        = 2,     // dark cycles at the start of a slot, >= 1
    parameter int COLON_FRAMES = 50     // frames between colon toggles, >= 1
) (
    input  logic          clk,
    input  logic          rst,
    time_display_if.slave disp
);

    localparam int P_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W = (COLON_FRAMES > 1) ? $clog2(COLON_FRAMES) : 1;

    localparam logic [P_W-1:0]  P_LAST  = P_W'(SCAN_DIV - 1);
    localparam logic [P_W-1:0]  P_BLANK = P_W'(BLANK);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(COLON_FRAMES - 1);
    localparam logic [2:0]      K_LAST  = 3'd5;

    // Seven-segment decode; anything outside 0..9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    logic [P_W-1:0]  p_q, p_d;
    logic [2:0]      k_q, k_d;
    logic [3:0]      shadow_q [6];  // index 0 = l_sec ... 5 = m_hr
    logic [3:0]      shadow_d [6];
    logic [FC_W-1:0] fc_q, fc_d;
    logic            col_q, col_d;
    logic [5:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_done_q, frame_done_d;

    logic            p_wrap;
    logic            frame_end;
    logic            lz_dark;
    logic [3:0]      cur_digit;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        p_d          = p_q + 1'b1;
        k_d          = k_q;
        shadow_d     = shadow_q;
        fc_d         = fc_q;
        col_d        = col_q;
        an_d         = '0;
        seg_d        = '0;
        dp_d         = 1'b0;
        cur_digit    = 4'd0;

        p_wrap       = (p_q == P_LAST);
        frame_end    = p_wrap && (k_q == K_LAST);
        frame_done_d = frame_end;

        if (p_wrap) begin
            p_d = '0;
            k_d = (k_q == K_LAST) ? 3'd0 : k_q + 3'd1;
        end

        // The only point at which the inputs are sampled: start of a frame.
        if (p_q == '0 && k_q == 3'd0) begin
            shadow_d[0] = disp.l_sec;
            shadow_d[1] = disp.m_sec;
            shadow_d[2] = disp.l_min;
            shadow_d[3] = disp.m_min;
            shadow_d[4] = disp.l_hr;
            shadow_d[5] = disp.m_hr;
        end

        // Frame counter runs regardless of blink mode; only col is overridden.
        if (frame_end) begin
            if (fc_q == FC_LAST) begin
                fc_d  = '0;
                col_d = ~col_q;
            end else begin
                fc_d  = fc_q + 1'b1;
            end
        end
        if (!disp.colon_blink) begin
            col_d = 1'b1;
        end

        case (k_q)
            3'd0:    cur_digit = shadow_q[0];
            3'd1:    cur_digit = shadow_q[1];
            3'd2:    cur_digit = shadow_q[2];
            3'd3:    cur_digit = shadow_q[3];
            3'd4:    cur_digit = shadow_q[4];
            3'd5:    cur_digit = shadow_q[5];
            default: cur_digit = 4'd0;
        endcase

        // Leading-zero suppression darkens the whole m_hr slot, gap included.
        lz_dark = disp.lz_blank && (k_q == K_LAST) && (shadow_q[5] == 4'd0);

        if (p_q >= P_BLANK && !lz_dark) begin
            an_d  = 6'b000001 << k_q;
            seg_d = decode(cur_digit);
            dp_d  = col_q && (k_q == 3'd2 || k_q == 3'd4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q          <= '0;
            k_q          <= 3'd0;
            fc_q         <= '0;
            col_q        <= 1'b1;
            an_q         <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
            // NOTE: the shadow digits are reset along with the rest, because
            // the six 4-bit registers are flops, not a RAM, and must hold a
            // defined value until the first snapshot.
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= 4'd0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register sees the pre-edge values of the others.
            p_q          <= p_d;
            k_q          <= k_d;
            fc_q         <= fc_d;
            col_q        <= col_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign disp.an         = an_q;
    assign disp.seg        = seg_q;
    assign disp.dp         = dp_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_time_display_scan.sv
// -----------------------------------------------------------------------------
// tb_time_display_scan
// Bench for time_display_scan with SCAN_DIV=8, BLANK=2, COLON_FRAMES=2.
// A reference model derives the expected outputs from the edge count since
// reset release (slot/prescaler by division, frame-start snapshot, frame-count
// colon) and is compared against the DUT on every falling edge. Hand-computed
// literal expectations pin the startup, snapshot, dash, leading-zero, colon and
// mid-operation reset behaviour.
// -----------------------------------------------------------------------------
module tb_time_display_scan;

    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int CF    = 2;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din [6];   // 0 = l_sec ... 5 = m_hr
    logic       lz;
    logic       blink;

    time_display_if bus ();

    assign bus.l_sec       = din[0];
    assign bus.m_sec       = din[1];
    assign bus.l_min       = din[2];
    assign bus.m_min       = din[3];
    assign bus.l_hr        = din[4];
    assign bus.m_hr        = din[5];
    assign bus.lz_blank    = lz;
    assign bus.colon_blink = blink;

    time_display_scan #(
        .SCAN_DIV    (SD),
        .BLANK       (BL),
        .COLON_FRAMES(CF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .disp(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_of [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    int         n_edges = 0;
    int         frames  = 0;
    logic [3:0] snap [6];
    bit         col_m;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_edges = 0;
            frames  = 0;
            col_m   = 1'b1;
            {e_an, e_seg, e_dp, e_fd} = '0;
            foreach (snap[i]) snap[i] = 4'd0;
        end else begin
            int m, p, k;
            bit fend;
            m = n_edges;
            n_edges++;
            p = m % SD;
            k = (m / SD) % 6;
            if (p < BL || (lz && k == 5 && snap[5] == 4'd0)) begin
                {e_an, e_seg, e_dp} = '0;
            end else begin
                e_an  = 6'(1) << k;
                e_seg = seg_of[snap[k]];
                e_dp  = col_m && (k == 2 || k == 4);
            end
            if (m % FRAME == 0) snap = din;
            fend = (m % FRAME == FRAME - 1);
            e_fd = fend;
            if (fend) frames++;
            if (!blink)                        col_m = 1'b1;
            else if (fend && frames % CF == 0) col_m = ~col_m;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         chk_en  = 1'b0;
    int         cyc     = 0;
    int         last_fd = -1;
    logic [5:0] prev_an = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("an",         bus.an,         e_an);
            check("seg",        bus.seg,        e_seg);
            check("dp",         bus.dp,         e_dp);
            check("frame_done", bus.frame_done, e_fd);
            check("an_onehot0", 32'($onehot0(bus.an)), 1);
            check("an_hop", 32'(prev_an != 6'd0 && bus.an != 6'd0 && prev_an != bus.an), 0);
            if (rst) begin
                last_fd = -1;
            end else if (bus.frame_done === 1'b1) begin
                if (last_fd >= 0) check("fd_period", cyc - last_fd, FRAME);
                last_fd = cyc;
            end
        end
        cyc++;
        prev_an = bus.an;
    end

    // Advance to just after edge e (counted from reset release).
    task automatic goto_edge(input int e);
        while (n_edges < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [5:0] an0  [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
    logic [6:0] seg0 [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    logic       dp0  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        din   = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};   // 12:34:56
        lz    = 1'b0;
        blink = 1'b1;
        #2 rst = 1'b1;
        #10;
        check("rst_an",  bus.an,         0);
        check("rst_seg", bus.seg,        0);
        check("rst_dp",  bus.dp,         0);
        check("rst_fd",  bus.frame_done, 0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame 0: 12:34:56 walks out; inputs change mid-frame (slot 3).
        for (int k = 0; k < 6; k++) begin
            goto_edge(k * SD + 1);
            check("gap_an", bus.an, 0);
            goto_edge(k * SD + 3);
            check("f0_an",  bus.an,  an0[k]);
            check("f0_seg", bus.seg, seg0[k]);
            check("f0_dp",  bus.dp,  dp0[k]);
            if (k == 3) din = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2};  // 23:59:59
        end
        goto_edge(47); check("fd_47", bus.frame_done, 0);
        goto_edge(48); check("fd_48", bus.frame_done, 1);
        goto_edge(49); check("fd_49", bus.frame_done, 0);

        // Frame 1 shows the new snapshot.
        goto_edge(51); check("f1_lsec_seg", bus.seg, 7'h6F);
        goto_edge(67); check("f1_dp",       bus.dp,  1);
        goto_edge(91); check("f1_mhr_seg",  bus.seg, 7'h5B);
        check("f1_mhr_an", bus.an, 6'b100000);

        // Frame 2: colon off after two frames; prepare dash and zero hour.
        goto_edge(115); check("f2_dp_off", bus.dp, 0);
        din[0] = 4'hC;
        din[5] = 4'd0;
        lz     = 1'b1;

        // Frame 3: dash in slot 0, slot 5 dark throughout.
        goto_edge(147);
        check("dash_seg", bus.seg, 7'h40);
        check("dash_an",  bus.an,  6'b000001);
        for (int e = 185; e <= 192; e++) begin
            goto_edge(e);
            check("lz_an", bus.an, 0);
        end
        lz = 1'b0;

        // Frame 4: colon back on, zero hour visible.
        goto_edge(211); check("f4_dp_on", bus.dp, 1);
        goto_edge(235);
        check("zero_seg", bus.seg, 7'h3F);
        check("zero_an",  bus.an,  6'b100000);
        blink = 1'b0;

        // Frame 6 would have colon off if blinking; steady mode holds it on.
        goto_edge(307); check("colon_steady", bus.dp, 1);
        blink = 1'b1;
        goto_edge(419); check("colon_resume", bus.dp, 0);

        // Reset during slot 4 with p=5.
        goto_edge(9 * FRAME + 4 * SD + 5);
        check("pre_rst_an", bus.an, 6'b010000);
        #1 rst = 1'b1;
        #1;
        check("async_an",  bus.an,  0);
        check("async_seg", bus.seg, 0);
        check("async_dp",  bus.dp,  0);
        din = '{4'd0, 4'd3, 4'd0, 4'd2, 4'd0, 4'd1};   // 10:20:30
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        goto_edge(3);
        check("restart_an",  bus.an,  6'b000001);
        check("restart_seg", bus.seg, 7'h3F);
        goto_edge(11);
        check("restart_s1",  bus.seg, 7'h4F);

        // Random: ten frames of random digits and controls.
        for (int c = 0; c < 10 * FRAME; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < 5; i++) din[i] = 4'($urandom_range(0, 15));
                din[5] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0)  lz    = ~lz;
            if ($urandom_range(0, 199) == 0) blink = ~blink;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/time_display_scan.md
# time_display_scan

Multiplexed six-digit seven-segment display driver that consumes the BCD HH:MM:SS digits produced by the time counter and scans them onto a common-segment display. It takes a tear-free snapshot of all six digits at the start of each scan frame and drives one digit per slot with an anti-ghosting blank gap. A blinking colon is shown on the l_hr and l_min decimal points. Invalid BCD digits render as a dash.

## Interface
- SCAN_DIV, 1000, clock cycles per digit slot; must be ≥ BLANK+1
- BLANK, 2, blank cycles at the start of each slot; must be ≥ 1
- COLON_FRAMES, 50, frames between colon toggles; must be ≥ 1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m_hr, l_hr, m_min, l_min, m_sec, l_sec  in  4 each  BCD time digits
- lz_blank  in  1  when high, blanks the m_hr digit if its snapshot is 0
- colon_blink  in  1  1 = colon toggles; 0 = colon steady on
- an  out  6  one-hot digit enable, active high; bit 0 = l_sec, 1 = m_sec, 2 = l_min, 3 = m_min, 4 = l_hr, 5 = m_hr
- seg  out  7  segments {g,f,e,d,c,b,a}, active high
- dp  out  1  decimal point, active high
- frame_done  out  1  one-cycle pulse at the end of each six-slot frame

## Operation
- State:
  - prescaler p counts 0..SCAN_DIV-1.
  - slot index k counts 0..5.
  - six 4-bit shadow digits.
  - frame counter fc counts 0..COLON_FRAMES-1.
  - colon flag col.
- Each edge: p increments. When p==SCAN_DIV-1, p goes to 0 and k advances (5 wraps to 0).
- Snapshot: on each edge where pre-edge p==0 and k==0, all six inputs load into the shadow registers. This includes the first edge after reset release. Inputs are never sampled at any other time, so a counter rollover mid-frame cannot tear the display.
- All outputs are registered and computed from pre-edge state (p, k, shadow, col):
  - If p<BLANK: an=0, seg=0, dp=0.
  - If p≥BLANK: an=one-hot(k), seg=decode(shadow[k]), dp=col when k is 2 or 4, else dp=0.
  - Leading-zero blank: if lz_blank=1, k==5 and shadow m_hr==0, then an=0, seg=0 and dp=0 for the whole slot.
- Decode table:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66
  - 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F
  - 10..15→0x40 (dash)
- Frame end occurs on the edge where pre-edge k==5 and p==SCAN_DIV-1:
  - frame_done is registered high for exactly the following cycle.
  - fc advances.
  - When fc wraps from COLON_FRAMES-1 to 0, col toggles.
- col is forced to 1 whenever colon_blink=0; fc keeps counting.
- Counter widths are $clog2 of their ranges. No arithmetic is performed on the digit values.

## Timing
- Reset (asynchronous assert, any cycle): p=0, k=0, fc=0, col=1, shadow=0, an=0, seg=0, dp=0, frame_done=0. Reset mid-slot aborts the scan immediately. Outputs go dark with no glitch to another digit.
- Counting edges from reset release:
  - Edge 1 snapshots the inputs.
  - an becomes 6'b000001 after edge BLANK+1.
  - Digit k is lit for SCAN_DIV-BLANK cycles per slot, with BLANK dark cycles between slots.
- Frame period is 6·SCAN_DIV cycles. frame_done is first high after edge 6·SCAN_DIV, then every 6·SCAN_DIV cycles.
- Input change to display update latency: up to one frame plus BLANK+1 cycles.
- At most one bit of an is high in any cycle. an never changes in the same cycle as seg, except to or from all-zero.

## Test plan
- Reset/startup (SCAN_DIV=8, BLANK=2): hold inputs 12:34:56, release rst.
  - Over slots 0..5, an walks 000001..100000 with seg 0x7D, 0x6D, 0x66, 0x4F, 0x5B, 0x06.
  - an=0 during the 2-cycle gaps.
  - frame_done pulses at cycle 48.
- Snapshot: change the inputs to 23:59:59 at slot 3 mid-frame.
  - The current frame still shows 12:34:56.
  - The next frame shows the new value; no mixed frame appears.
- Invalid/blank: set l_sec=4'hC → seg=0x40 in slot 0.
  - With lz_blank=1 and m_hr=0 → an stays 0 for all of slot 5.
  - With lz_blank=0 → 0x3F is shown in slot 5.
- Colon (COLON_FRAMES=2, colon_blink=1):
  - dp is high only in slots 2 and 4, and only in the non-blank part of those slots.
  - col toggles every 2 frames.
  - colon_blink=0 holds dp on.
- Reset mid-operation: assert rst during slot 4 at p=5.
  - Outputs go to 0 asynchronously.
  - After release, the scan restarts at slot 0 with a fresh snapshot.
- One-hot check: over 10 frames with random inputs, assert $onehot0(an) every cycle and the frame_done period of 48 cycles.
